kbd_display_driver: RTL and testbench
=====================================

# kbd_display_driver

Multiplexed 4-digit seven-segment driver that sits directly downstream of the PS/2 keyboard controller. It consumes the controller's `scancode` / `prevscancode` byte pair and shows both as hexadecimal on the board's common-anode display. Whenever a new key release arrives, it flashes the decimal points for a fixed window. It is the first user-visible stage of the keyboard path.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000: input clock frequency.
- `REFRESH_HZ`, 1000: per-digit switch rate. `DIV = CLK_HZ/REFRESH_HZ` clock cycles per digit slot; `DIV` must be ≥ 2.
- `FLASH_MS`, 250: decimal-point flash duration. `FLASH_CYCLES = (CLK_HZ/1000)*FLASH_MS`; must be ≥ 1.

Ports:
- `clk_100MHz`  in  1  system clock; the single clock.
- `reset`  in  1  asynchronous, active-low reset.
- `scancode`  in  8  last released key, synchronous to `clk_100MHz`.
- `prevscancode`  in  8  key released before it, synchronous to `clk_100MHz`.
- `an`  out  4  digit anodes, active-low; `an[3]` is the leftmost digit.
- `seg`  out  7  segments a..g, active-low; `seg[0]` = a, `seg[6]` = g.
- `dp`  out  1  decimal point, active-low.

## Operation
- **Capture:** a 16-bit register `cap` loads `{prevscancode, scancode}` every cycle; reset value 0.
- **New-key detection:** `new_key` = (`{prevscancode, scancode}` != `cap`), evaluated combinationally in the same cycle.
  - A change of either byte counts as a new key.
  - A release that changes neither byte (e.g. a third consecutive release of the same key) is not detected. This is by design.
  - A first key with both bytes equal to 0x00 is not detected.
- **Valid flag:** `valid` (reset 0) sets on the first `new_key` and stays set until reset.
- **Flash counter:** width `clog2(FLASH_CYCLES+1)`, reset 0.
  - On `new_key` it loads `FLASH_CYCLES`; otherwise it decrements while nonzero.
  - `flash_on` = (counter != 0).
  - A `new_key` during an active flash reloads the counter (retrigger; the window is extended, not stacked).
- **Prescaler:** counts 0..DIV-1 and wraps to 0. On terminal count (DIV-1), the 2-bit digit index `idx` increments 0→1→2→3→0. Reset: prescaler 0, `idx` 0.
- **Digit mapping:**
  - `idx` 3 → `prevscancode[7:4]`
  - `idx` 2 → `prevscancode[3:0]`
  - `idx` 1 → `scancode[7:4]`
  - `idx` 0 → `scancode[3:0]`
  - All nibbles come from `cap`.
- **Hex decode:** standard patterns for 0-9 and A, b, C, d, E, F. Examples (active-low `seg[6:0]`): 0 = 7'b1000000, 1 = 7'b1111001, F = 7'b0001110.
- **Before `valid`:** every digit shows a dash, `seg` = 7'b0111111.
- **Anodes:** `an` = `~(4'b0001 << idx)`; exactly one anode is low at any time after reset.
- **Decimal point:**
  - `dp` = 0 on `idx` 2 whenever `valid` (fixed separator between the two bytes).
  - `dp` = 0 on every digit while `flash_on`.
  - `dp` = 1 otherwise.

## Timing
- `an`, `seg` and `dp` are registered and reflect `idx`/`cap`/`flash_on` from the previous cycle. Latency is 1 cycle.
- **Reset values:** `an` = 4'b1111 (all off), `seg` = 7'b1111111, `dp` = 1. The first post-reset clock edge drives digit 0 with a dash.
- **Input change at edge N:** `cap`, `valid` and the flash counter update at edge N. The new digits and lit dp appear at edge N+1.
- **Flash window:** `dp` stays low for exactly `FLASH_CYCLES` output cycles, then returns to separator-only behaviour.
- **Simultaneous `new_key` and prescaler terminal count:** both take effect at the same edge, independently.
- **Reset asserted mid-operation:** all state returns to reset values immediately (asynchronously), including a flash in progress. After release, the display shows dashes again until the next key.

## Structure
- **Shared package `kbd_pkg`:** segment-pattern constants `SEG_DASH` and `SEG_OFF`, and the 16-entry hex-to-segment constant table. The keyboard path and any later display blocks share these.
- **Sub-module `hex_to_7seg`:** purely combinational, 4-bit nibble in, 7-bit active-low segments out. Instantiated once, fed by a nibble mux on `idx`.
- **Top level contents:** capture register, change detect, valid flag, flash counter, prescaler, `idx`, and the output registers.

## Test plan
All scenarios use `CLK_HZ`=1000, `REFRESH_HZ`=250 (`DIV`=4) and `FLASH_MS`=10 (`FLASH_CYCLES`=10).
- **Reset and dashes:** assert `reset`=0, then release.
  - During reset: `an`=1111, `seg`=1111111, `dp`=1.
  - After release: `an` walks 1110→1101→1011→0111, 4 cycles per digit, with `seg`=0111111 on every digit.
- **First key:** `scancode`=0x1C, `prevscancode`=0x00.
  - Digits 3..0 show 0, 0, 1, C: `seg`=1000000, 1000000, 1111001, 1000110.
  - `dp`=0 on all digits for exactly 10 cycles, then only on digit 2.
- **Retrigger:** change `scancode` to 0x32 five cycles into a flash. `dp` stays low for 10 cycles measured from the second change (15 total).
- **Undetected repeat:** drive the same pair 0x1C/0x1C twice. No flash occurs on the second drive; the display is unchanged.
- **Reset mid-flash:** pulse `reset` low for one cycle during a flash.
  - Outputs go to reset values asynchronously, mid-cycle.
  - After release, dashes return and `dp`=1.
- **Coincident events:** change input on the same cycle as prescaler count 3. `idx` advances and the new nibble appears on the next digit one cycle later; no slot is skipped or doubled.

Source files
------------

// File: rtl/kbd_display_driver_pkg.sv
// Shared segment patterns and hex-to-segment table for the keyboard display path.
// All patterns are active-low, bit order {g,f,e,d,c,b,a}.
package kbd_pkg;

   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_OFF  = 7'b1111111;
   localparam logic [3:0] AN_OFF   = 4'b1111;
   localparam logic [1:0] SEP_IDX  = 2'd2;

   localparam logic [6:0] HEX_SEG [0:15] = '{
      7'b1000000,   // 0
      7'b1111001,   // 1
      7'b0100100,   // 2
      7'b0110000,   // 3
      7'b0011001,   // 4
      7'b0010010,   // 5
      7'b0000010,   // 6
      7'b1111000,   // 7
      7'b0000000,   // 8
      7'b0010000,   // 9
      7'b0001000,   // A
      7'b0000011,   // b
      7'b1000110,   // C
      7'b0100001,   // d
      7'b0000110,   // E
      7'b0001110    // F
   };

   // One-hot active-low anode pattern for a digit slot.
   function automatic logic [3:0] anode_sel(input logic [1:0] idx);
      logic [3:0] onehot;
      onehot = 4'b0001 << idx;
      return ~onehot;
   endfunction

endpackage

// File: rtl/kbd_display_driver_hex.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_7seg
   import kbd_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/kbd_display_driver.sv
// Four-digit multiplexed hex display of the last two PS/2 scancodes, with a
// decimal-point flash on every newly observed key.
module kbd_display_driver
   import kbd_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int REFRESH_HZ = 1000,
   parameter int FLASH_MS   = 250
)(
   input  logic       clk_100MHz,
   input  logic       reset,
   input  logic [7:0] scancode,
   input  logic [7:0] prevscancode,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int DIV          = CLK_HZ / REFRESH_HZ;
   localparam int FLASH_CYCLES = (CLK_HZ / 1000) * FLASH_MS;
   localparam int PW           = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int FW           = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES + 1) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
   localparam logic [PW-1:0] PRESC_ZERO = PW'(0);
   localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
   localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_CYCLES);
   localparam logic [FW-1:0] FLASH_ZERO = FW'(0);
   localparam logic [FW-1:0] FLASH_ONE  = FW'(1);

   logic [15:0]   cap_q,   cap_d;
   logic          valid_q, valid_d;
   logic [FW-1:0] flash_q, flash_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [1:0]    idx_q,   idx_d;
   logic [3:0]    an_q,    an_d;
   logic [6:0]    seg_q,   seg_d;
   logic          dp_q,    dp_d;

   logic [15:0]   pair_s;
   logic          new_key_s;
   logic          flash_on_s;
   logic          presc_tc_s;
   logic [3:0]    nibble_s;
   logic [6:0]    hex_seg_s;

   assign pair_s     = {prevscancode, scancode};
   // Only a change of the byte pair is visible; identical repeats are ignored.
   assign new_key_s  = (pair_s != cap_q);
   assign flash_on_s = (flash_q != FLASH_ZERO);
   assign presc_tc_s = (presc_q == PRESC_LAST);

   // Select the nibble for the digit slot currently being driven.
   always_comb begin
      nibble_s = 4'h0;
      case (idx_q)
         2'd3:    nibble_s = cap_q[15:12];
         2'd2:    nibble_s = cap_q[11:8];
         2'd1:    nibble_s = cap_q[7:4];
         2'd0:    nibble_s = cap_q[3:0];
         default: nibble_s = 4'h0;
      endcase
   end

   hex_to_7seg u_hex (
      .nibble_i (nibble_s),
      .seg_o    (hex_seg_s)
   );

   // Capture, key-valid flag and retriggerable flash window.
   always_comb begin
      cap_d   = pair_s;
      valid_d = valid_q;
      flash_d = flash_q;
      if (new_key_s) begin
         valid_d = 1'b1;
         flash_d = FLASH_LOAD;
      end else if (flash_on_s) begin
         flash_d = flash_q - FLASH_ONE;
      end else begin
         flash_d = FLASH_ZERO;
      end
   end

   // Refresh prescaler and digit index; the index steps on terminal count.
   always_comb begin
      presc_d = presc_q;
      idx_d   = idx_q;
      if (presc_tc_s) begin
         presc_d = PRESC_ZERO;
         idx_d   = idx_q + 2'd1;
      end else begin
         presc_d = presc_q + PRESC_ONE;
      end
   end

   // Output pattern for the current slot, registered on the next edge.
   always_comb begin
      an_d  = anode_sel(idx_q);
      seg_d = SEG_DASH;
      dp_d  = 1'b1;
      if (valid_q) begin
         seg_d = hex_seg_s;
      end else begin
         seg_d = SEG_DASH;
      end
      if (flash_on_s || (valid_q && (idx_q == SEP_IDX))) begin
         dp_d = 1'b0;
      end else begin
         dp_d = 1'b1;
      end
   end

   // State and output registers.
   always_ff @(posedge clk_100MHz or negedge reset) begin
      if (!reset) begin
         cap_q   <= 16'h0000;
         valid_q <= 1'b0;
         flash_q <= FLASH_ZERO;
         presc_q <= PRESC_ZERO;
         idx_q   <= 2'd0;
         an_q    <= AN_OFF;
         seg_q   <= SEG_OFF;
         dp_q    <= 1'b1;
      end else begin
         cap_q   <= cap_d;
         valid_q <= valid_d;
         flash_q <= flash_d;
         presc_q <= presc_d;
         idx_q   <= idx_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_kbd_display_driver.sv
// Self-checking bench for kbd_display_driver: per-cycle scoreboard plus
// scenario tasks with fixed expected patterns.
module tb_kbd_display_driver;

   localparam int CLK_HZ     = 1000;
   localparam int REFRESH_HZ = 250;
   localparam int FLASH_MS   = 10;
   localparam int DIV        = 4;
   localparam int FLASH_CYC  = 10;
   localparam logic [6:0] DASH = 7'b0111111;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] scancode = 8'h00;
   logic [7:0] prevscancode = 8'h00;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } out_t;

   out_t        exp_q[$];
   logic [15:0] m_cap   = 16'h0000;
   logic        m_valid = 1'b0;
   int          m_flash = 0;
   int          m_presc = 0;
   int          m_idx   = 0;
   bit          sb_en   = 1'b0;

   kbd_display_driver #(
      .CLK_HZ     (CLK_HZ),
      .REFRESH_HZ (REFRESH_HZ),
      .FLASH_MS   (FLASH_MS)
   ) dut (
      .clk_100MHz   (clk),
      .reset        (reset),
      .scancode     (scancode),
      .prevscancode (prevscancode),
      .an           (an),
      .seg          (seg),
      .dp           (dp)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] hexref(input logic [3:0] n);
      case (n)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;
         4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   function automatic logic [3:0] an_exp(input int k);
      logic [3:0] oh;
      oh = 4'b0001 << (k % 4);
      return ~oh;
   endfunction

   // Reference model: pushes the expected registered outputs for each edge.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_cap   <= 16'h0000;
         m_valid <= 1'b0;
         m_flash <= 0;
         m_presc <= 0;
         m_idx   <= 0;
         exp_q.delete();
      end else begin
         exp_q.push_back({an_exp(m_idx),
                          (m_valid ? hexref(m_cap[m_idx*4 +: 4]) : DASH),
                          ~((m_flash != 0) || (m_valid && (m_idx == 2)))});
         if ({prevscancode, scancode} != m_cap) begin
            m_valid <= 1'b1;
            m_flash <= FLASH_CYC;
         end else if (m_flash > 0) begin
            m_flash <= m_flash - 1;
         end
         m_cap <= {prevscancode, scancode};
         if (m_presc == DIV - 1) begin
            m_presc <= 0;
            m_idx   <= (m_idx + 1) % 4;
         end else begin
            m_presc <= m_presc + 1;
         end
      end
   end

   // Scoreboard: compare every output cycle against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (sb_en && reset) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL sb_empty: no expected entry at t=%0t", $time);
            end else begin
               out_t e;
               e = exp_q.pop_front();
               if ({an, seg, dp} !== e) begin
                  bad++;
                  $display("FAIL sb_out t=%0t: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                           $time, an, seg, dp, e.an, e.seg, e.dp);
               end
            end
         end
      end
   end

   task automatic test_reset();
      logic [3:0] e_an;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      total++;
      if (an !== 4'b1111) begin bad++; $display("FAIL reset_an: got %b want 1111", an); end
      total++;
      if (seg !== 7'b1111111) begin bad++; $display("FAIL reset_seg: got %b want 1111111", seg); end
      total++;
      if (dp !== 1'b1) begin bad++; $display("FAIL reset_dp: got %b want 1", dp); end
      @(negedge clk);
      #1;
      reset = 1'b1;
      sb_en = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         e_an = an_exp((k - 1) / 4);
         total++;
         if (an !== e_an || seg !== DASH || dp !== 1'b1) begin
            bad++;
            $display("FAIL dash_walk c%0d: got an=%b seg=%b dp=%b want an=%b seg=%b dp=1",
                     k, an, seg, dp, e_an, DASH);
         end
      end
   endtask

   task automatic test_first_key();
      int low_cnt = 0;
      int sep_err = 0;
      logic [6:0] seen [4];
      for (int d = 0; d < 4; d++) seen[d] = 7'b1111111;
      #1;
      prevscancode = 8'h00;
      scancode     = 8'h1C;
      for (int i = 1; i <= 24; i++) begin
         @(negedge clk);
         if (i == 1) begin
            total++;
            if (dp !== 1'b1 || seg !== DASH) begin
               bad++;
               $display("FAIL first_latency: got seg=%b dp=%b want seg=%b dp=1", seg, dp, DASH);
            end
         end
         if (i >= 2 && i <= 11 && dp === 1'b0) low_cnt++;
         if (i >= 12 && dp !== ((an === 4'b1011) ? 1'b0 : 1'b1)) sep_err++;
         if (i >= 2) begin
            case (an)
               4'b1110: seen[0] = seg;
               4'b1101: seen[1] = seg;
               4'b1011: seen[2] = seg;
               4'b0111: seen[3] = seg;
               default: ;
            endcase
         end
      end
      total++;
      if (low_cnt != 10) begin bad++; $display("FAIL first_flash_len: got %0d want 10", low_cnt); end
      total++;
      if (sep_err != 0) begin bad++; $display("FAIL first_sep_dp: got %0d errors want 0", sep_err); end
      total++;
      if (seen[3] !== 7'b1000000) begin bad++; $display("FAIL first_dig3: got %b want 1000000", seen[3]); end
      total++;
      if (seen[2] !== 7'b1000000) begin bad++; $display("FAIL first_dig2: got %b want 1000000", seen[2]); end
      total++;
      if (seen[1] !== 7'b1111001) begin bad++; $display("FAIL first_dig1: got %b want 1111001", seen[1]); end
      total++;
      if (seen[0] !== 7'b1000110) begin bad++; $display("FAIL first_dig0: got %b want 1000110", seen[0]); end
   endtask

   task automatic test_retrigger();
      int low_cnt = 0;
      int sep_err = 0;
      #1;
      prevscancode = 8'h1C;
      scancode     = 8'h24;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (i >= 2 && i <= 16) begin
            if (dp === 1'b0) low_cnt++;
         end else if (dp !== ((an === 4'b1011) ? 1'b0 : 1'b1)) begin
            sep_err++;
         end
         if (i == 5) begin
            #1;
            scancode = 8'h32;
         end
      end
      total++;
      if (low_cnt != 15) begin bad++; $display("FAIL retrig_len: got %0d want 15", low_cnt); end
      total++;
      if (sep_err != 0) begin bad++; $display("FAIL retrig_sep: got %0d errors want 0", sep_err); end
   endtask

   task automatic test_repeat();
      int sep_err = 0;
      logic [6:0] seen [4];
      for (int d = 0; d < 4; d++) seen[d] = 7'b1111111;
      #1;
      prevscancode = 8'h1C;
      scancode     = 8'h1C;
      repeat (20) @(negedge clk);
      #1;
      prevscancode = 8'h1C;
      scancode     = 8'h1C;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (dp !== ((an === 4'b1011) ? 1'b0 : 1'b1)) sep_err++;
         case (an)
            4'b1110: seen[0] = seg;
            4'b1101: seen[1] = seg;
            4'b1011: seen[2] = seg;
            4'b0111: seen[3] = seg;
            default: ;
         endcase
      end
      total++;
      if (sep_err != 0) begin bad++; $display("FAIL repeat_no_flash: got %0d errors want 0", sep_err); end
      total++;
      if (seen[3] !== 7'b1111001) begin bad++; $display("FAIL repeat_dig3: got %b want 1111001", seen[3]); end
      total++;
      if (seen[0] !== 7'b1000110) begin bad++; $display("FAIL repeat_dig0: got %b want 1000110", seen[0]); end
   endtask

   task automatic test_reset_mid_flash();
      int err = 0;
      #1;
      prevscancode = 8'h1C;
      scancode     = 8'h5A;
      repeat (3) @(negedge clk);
      total++;
      if (dp !== 1'b0) begin bad++; $display("FAIL midrst_flash_active: got dp=%b want 0", dp); end
      #1;
      reset        = 1'b0;
      prevscancode = 8'h00;
      scancode     = 8'h00;
      #1;
      total++;
      if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
         bad++;
         $display("FAIL midrst_async: got an=%b seg=%b dp=%b want 1111 1111111 1", an, seg, dp);
      end
      @(negedge clk);
      #1;
      reset = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (an !== an_exp((i - 1) / 4) || seg !== DASH || dp !== 1'b1) err++;
      end
      total++;
      if (err != 0) begin bad++; $display("FAIL midrst_dashes: got %0d errors want 0", err); end
   endtask

   task automatic test_coincident();
      bit found = 1'b0;
      int k;
      logic [15:0] pair;
      for (int t = 0; t < 8 && !found; t++) begin
         if (m_presc == DIV - 1) found = 1'b1;
         else @(negedge clk);
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL coinc_phase: got no terminal count within 8 cycles want one");
      end else begin
         k    = m_idx;
         pair = 16'h3E7F;
         #1;
         prevscancode = pair[15:8];
         scancode     = pair[7:0];
         @(negedge clk);
         total++;
         if (an !== an_exp(k) || seg !== DASH) begin
            bad++;
            $display("FAIL coinc_old_slot: got an=%b seg=%b want an=%b seg=%b", an, seg, an_exp(k), DASH);
         end
         @(negedge clk);
         total++;
         if (an !== an_exp(k + 1) || seg !== hexref(pair[((k + 1) % 4)*4 +: 4])) begin
            bad++;
            $display("FAIL coinc_new_slot: got an=%b seg=%b want an=%b seg=%b",
                     an, seg, an_exp(k + 1), hexref(pair[((k + 1) % 4)*4 +: 4]));
         end
         repeat (3) @(negedge clk);
         total++;
         if (an !== an_exp(k + 1)) begin
            bad++;
            $display("FAIL coinc_slot_len: got an=%b want %b", an, an_exp(k + 1));
         end
         @(negedge clk);
         total++;
         if (an !== an_exp(k + 2) || seg !== hexref(pair[((k + 2) % 4)*4 +: 4])) begin
            bad++;
            $display("FAIL coinc_next_slot: got an=%b seg=%b want an=%b seg=%b",
                     an, seg, an_exp(k + 2), hexref(pair[((k + 2) % 4)*4 +: 4]));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_first_key();
      test_retrigger();
      test_repeat();
      test_reset_mid_flash();
      test_coincident();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
